rgb_pattern_gen: RTL



---
 rtl/rgb_pattern_pkg.sv | 32 +++
 rtl/rgb_pos_tracker.sv | 129 ++++++++++++
 rtl/rgb_pattern_gen.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/rgb_pattern_pkg.sv
// -----------------------------------------------------------------------------
// rgb_pattern_pkg
// Shared definitions for the RGB test-pattern generator:
//   - mode_e      : pattern-select encodings (values 5-7 are unnamed = black)
//   - RAINBOW     : 8-entry 24-bit {R,G,B} colour-bar table, index 0 = red
//   - scale_chan  : maps an 8-bit table channel onto a w-bit channel
// -----------------------------------------------------------------------------
package rgb_pattern_pkg;

    typedef enum logic [2:0] {
        MODE_SOLID  = 3'd0,
        MODE_BARS   = 3'd1,
        MODE_GRAD   = 3'd2,
        MODE_CHECK  = 3'd3,
        MODE_SCROLL = 3'd4
    } mode_e;

    // Packed so that RAINBOW[i] selects entry i; entry 0 is the last one listed.
    localparam logic [7:0][23:0] RAINBOW = {
        24'h000000, 24'h9400D3, 24'h4B0082, 24'h0000FF,
        24'h00FF00, 24'hFFFF00, 24'hFF7F00, 24'hFF0000
    };

    // MSB-align an 8-bit channel into a w-bit result held in the low w bits.
    // w < 8 keeps the top w bits; w > 8 zero-fills the LSBs.
    function automatic logic [31:0] scale_chan(input logic [7:0] c, input int unsigned w);
        logic [31:0] aligned;
        aligned = {c, 24'h000000};
        return aligned >> (32'd32 - w);
    endfunction

endpackage

// File: rtl/rgb_pos_tracker.sv
// -----------------------------------------------------------------------------
// rgb_pos_tracker
// Derives the pixel position from the sync/blank strobes and keeps frame state.
// Ports:
//   i_clk, i_rst      pixel clock, synchronous active-high reset
//   i_vsync, i_blank  timing strobes (same cycle as the pixel being tracked)
//   i_mode            pattern select, captured on the vsync rising edge
//   o_x, o_y          position of the current pixel (saturating)
//   o_bar             colour-bar index of the current pixel (saturating)
//   o_frame           8-bit wrapping frame counter
//   o_mode            mode latched at the last frame start
//   o_vs_rise         combinational vsync rising-edge strobe for this cycle
// -----------------------------------------------------------------------------
module rgb_pos_tracker
    import rgb_pattern_pkg::*;
#(
    parameter int H_ACTIVE  = 640,
    parameter int V_ACTIVE  = 480,
    parameter int CNT_W     = 12,
    parameter int BAR_COUNT = 8
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_vsync,
    input  logic             i_blank,
    input  logic [2:0]       i_mode,
    output logic [CNT_W-1:0] o_x,
    output logic [CNT_W-1:0] o_y,
    output logic [2:0]       o_bar,
    output logic [7:0]       o_frame,
    output logic [2:0]       o_mode,
    output logic             o_vs_rise
);

    localparam int               BW      = H_ACTIVE / BAR_COUNT;
    localparam logic [CNT_W-1:0] X_MAX   = CNT_W'(H_ACTIVE - 1);
    localparam logic [CNT_W-1:0] Y_MAX   = CNT_W'(V_ACTIVE - 1);
    localparam logic [CNT_W-1:0] BW_LAST = CNT_W'(BW - 1);
    localparam logic [2:0]       BAR_MAX = 3'(BAR_COUNT - 1);

    logic [CNT_W-1:0] x_q, x_d, y_q, y_d, bcnt_q, bcnt_d;
    logic [2:0]       bar_q, bar_d, mode_q, mode_d;
    logic [7:0]       frame_q, frame_d;
    logic             vs_prev_q, bl_prev_q;
    logic             vs_rise_s, bl_fall_s;

    assign vs_rise_s = i_vsync & ~vs_prev_q;
    // End of an active run: first blanked cycle after an unblanked one.
    assign bl_fall_s = i_blank & ~bl_prev_q;

    // Next-state for position, bar and frame state.
    always_comb begin
        x_d     = x_q;
        y_d     = y_q;
        bcnt_d  = bcnt_q;
        bar_d   = bar_q;
        frame_d = frame_q;
        mode_d  = mode_q;
        if (i_blank) begin
            x_d    = '0;
            bcnt_d = '0;
            bar_d  = 3'd0;
        end else begin
            if (x_q != X_MAX) begin
                x_d = x_q + CNT_W'(1);
            end else begin
                x_d = x_q;
            end
            // bcnt counts pixels within the current bar; the bar index
            // advances once a full bar width has been emitted.
            if (bcnt_q == BW_LAST) begin
                bcnt_d = '0;
                if (bar_q != BAR_MAX) begin
                    bar_d = bar_q + 3'd1;
                end else begin
                    bar_d = bar_q;
                end
            end else begin
                bcnt_d = bcnt_q + CNT_W'(1);
                bar_d  = bar_q;
            end
        end
        // A frame start wins over a same-cycle line end.
        if (vs_rise_s) begin
            y_d     = '0;
            frame_d = frame_q + 8'd1;
            mode_d  = i_mode;
        end else if (bl_fall_s) begin
            if (y_q != Y_MAX) begin
                y_d = y_q + CNT_W'(1);
            end else begin
                y_d = y_q;
            end
        end else begin
            y_d = y_q;
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            x_q       <= '0;
            y_q       <= '0;
            bcnt_q    <= '0;
            bar_q     <= 3'd0;
            frame_q   <= 8'd0;
            mode_q    <= 3'd0;
            vs_prev_q <= 1'b0;
            bl_prev_q <= 1'b1;
        end else begin
            x_q       <= x_d;
            y_q       <= y_d;
            bcnt_q    <= bcnt_d;
            bar_q     <= bar_d;
            frame_q   <= frame_d;
            mode_q    <= mode_d;
            vs_prev_q <= i_vsync;
            bl_prev_q <= i_blank;
        end
    end

    assign o_x       = x_q;
    assign o_y       = y_q;
    assign o_bar     = bar_q;
    assign o_frame   = frame_q;
    assign o_mode    = mode_q;
    assign o_vs_rise = vs_rise_s;

endmodule

// File: rtl/rgb_pattern_gen.sv
// -----------------------------------------------------------------------------
// rgb_pattern_gen
// Video test-pattern generator placed between the timing generator and the
// TMDS encoder. Stage 1 computes the pattern colour for the current pixel,
// stage 2 blanks it and registers all outputs: every output lags its input
// by 2 cycles.
// Ports:
//   i_clk, i_rst                  pixel clock, synchronous active-high reset
//   i_hsync, i_vsync, i_blank     timing strobes in
//   i_mode                        pattern select, latched on vsync rise
//   i_solid_rgb                   {R,G,B} colour for solid mode
//   o_hsync, o_vsync, o_blank     timing strobes, delayed 2 cycles
//   o_red, o_green, o_blue        pixel colour, 0 while blanked
//   o_frame_start                 pulse aligned with the o_vsync rising edge
// Build option: define RGB_PATTERN_BORDER_EN for a 1-pixel white border.
// -----------------------------------------------------------------------------
module rgb_pattern_gen
    import rgb_pattern_pkg::*;
#(
    parameter int H_ACTIVE   = 640,
    parameter int V_ACTIVE   = 480,
    parameter int COLOR_W    = 8,
    parameter int CNT_W      = 12,
    parameter int BAR_COUNT  = 8,
    parameter int CHECK_LOG2 = 5
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_hsync,
    input  logic                 i_vsync,
    input  logic                 i_blank,
    input  logic [2:0]           i_mode,
    input  logic [3*COLOR_W-1:0] i_solid_rgb,
    output logic                 o_hsync,
    output logic                 o_vsync,
    output logic                 o_blank,
    output logic [COLOR_W-1:0]   o_red,
    output logic [COLOR_W-1:0]   o_green,
    output logic [COLOR_W-1:0]   o_blue,
    output logic                 o_frame_start
);

    localparam int   RGB_W    = 3 * COLOR_W;
    localparam logic [2:0] BAR_MASK = 3'(BAR_COUNT - 1);

    logic [CNT_W-1:0] x_s, y_s;
    logic [2:0]       bar_s, mode_s, scroll_idx_s;
    logic [7:0]       frame_s;
    logic             vs_rise_s;
    logic [RGB_W-1:0] pat_s, rgb_d, out_rgb_d;

    logic             s1_hs_q, s1_vs_q, s1_bl_q, s1_fs_q;
    logic [RGB_W-1:0] s1_rgb_q;
    logic             hs_q, vs_q, bl_q, fs_q;
    logic [RGB_W-1:0] rgb_q;

    rgb_pos_tracker #(
        .H_ACTIVE  (H_ACTIVE),
        .V_ACTIVE  (V_ACTIVE),
        .CNT_W     (CNT_W),
        .BAR_COUNT (BAR_COUNT)
    ) u_pos (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .i_vsync   (i_vsync),
        .i_blank   (i_blank),
        .i_mode    (i_mode),
        .o_x       (x_s),
        .o_y       (y_s),
        .o_bar     (bar_s),
        .o_frame   (frame_s),
        .o_mode    (mode_s),
        .o_vs_rise (vs_rise_s)
    );

    function automatic logic [RGB_W-1:0] expand_rgb(input logic [23:0] c);
        return {COLOR_W'(scale_chan(c[23:16], COLOR_W)),
                COLOR_W'(scale_chan(c[15:8],  COLOR_W)),
                COLOR_W'(scale_chan(c[7:0],   COLOR_W))};
    endfunction

    // Stage 1: pattern colour for the pixel at the current position.
    always_comb begin
        scroll_idx_s = (bar_s + frame_s[2:0]) & BAR_MASK;
        pat_s        = '0;
        case (mode_s)
            MODE_SOLID:  pat_s = i_solid_rgb;
            MODE_BARS:   pat_s = expand_rgb(RAINBOW[bar_s]);
            MODE_GRAD:   pat_s = {COLOR_W'(x_s), COLOR_W'(y_s),
                                  COLOR_W'(scale_chan(frame_s, COLOR_W))};
            MODE_CHECK:  pat_s = (x_s[CHECK_LOG2] ^ y_s[CHECK_LOG2]) ?
                                 {RGB_W{1'b0}} : {RGB_W{1'b1}};
            MODE_SCROLL: pat_s = expand_rgb(RAINBOW[scroll_idx_s]);
            default:     pat_s = '0;
        endcase
`ifdef RGB_PATTERN_BORDER_EN
        if ((x_s == '0) || (x_s == CNT_W'(H_ACTIVE - 1)) ||
            (y_s == '0) || (y_s == CNT_W'(V_ACTIVE - 1))) begin
            rgb_d = {RGB_W{1'b1}};
        end else begin
            rgb_d = pat_s;
        end
`else
        rgb_d = pat_s;
`endif
    end

    // Stage 2 colour: forced to black whenever the delayed blank is set.
    always_comb begin
        if (s1_bl_q) begin
            out_rgb_d = '0;
        end else begin
            out_rgb_d = s1_rgb_q;
        end
    end

    // Two-stage pipeline keeping strobes aligned with the colour data.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            s1_hs_q  <= 1'b0;
            s1_vs_q  <= 1'b0;
            s1_bl_q  <= 1'b1;
            s1_fs_q  <= 1'b0;
            s1_rgb_q <= '0;
            hs_q     <= 1'b0;
            vs_q     <= 1'b0;
            bl_q     <= 1'b1;
            fs_q     <= 1'b0;
            rgb_q    <= '0;
        end else begin
            s1_hs_q  <= i_hsync;
            s1_vs_q  <= i_vsync;
            s1_bl_q  <= i_blank;
            s1_fs_q  <= vs_rise_s;
            s1_rgb_q <= rgb_d;
            hs_q     <= s1_hs_q;
            vs_q     <= s1_vs_q;
            bl_q     <= s1_bl_q;
            fs_q     <= s1_fs_q;
            rgb_q    <= out_rgb_d;
        end
    end

    assign o_hsync       = hs_q;
    assign o_vsync       = vs_q;
    assign o_blank       = bl_q;
    assign o_frame_start = fs_q;
    assign o_red         = rgb_q[RGB_W-1:2*COLOR_W];
    assign o_green       = rgb_q[2*COLOR_W-1:COLOR_W];
    assign o_blue        = rgb_q[COLOR_W-1:0];

endmodule
